// File: rtl/hazard_scoreboard_if.sv
// Issue/Decode/writeback bundle between the pipeline front end and the
// register hazard scoreboard.
interface hazard_scoreboard_if #(
  parameter int NREGS = 32,
  parameter int REG_W = 5,
  parameter int ROW_W = 5,
  parameter int NCHK  = 2,
  parameter int NWB   = 2,
  parameter int CNT_W = 16
);
  logic                    flush;
  logic                    iss_valid;
  logic [NCHK*REG_W-1:0]   iss_src;
  logic [NCHK-1:0]         iss_check;
  logic                    iss_dst_en;
  logic [REG_W-1:0]        iss_dst;
  logic [ROW_W-1:0]        iss_row;
  logic                    iss_stalled;
  logic [NCHK*REG_W-1:0]   id_src;
  logic [NCHK-1:0]         id_check;
  logic                    id_stalled;
  logic [NWB-1:0]          wb_valid;
  logic [NWB*REG_W-1:0]    wb_dst;
  logic [NWB*ROW_W-1:0]    wb_row;
  logic [NREGS-1:0]        pending_vec;
  logic [CNT_W-1:0]        stall_cycles;

  modport master (
    output flush, iss_valid, iss_src, iss_check, iss_dst_en, iss_dst, iss_row,
           id_src, id_check, wb_valid, wb_dst, wb_row,
    input  iss_stalled, id_stalled, pending_vec, stall_cycles
  );

  modport slave (
    input  flush, iss_valid, iss_src, iss_check, iss_dst_en, iss_dst, iss_row,
           id_src, id_check, wb_valid, wb_dst, wb_row,
    output iss_stalled, id_stalled, pending_vec, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard: sets on issue, clears on a writeback
// carrying the matching row tag, and produces Issue/Decode stalls.
module hazard_scoreboard #(
  parameter int NREGS     = 32,
  parameter int REG_W     = 5,
  parameter int ROW_W     = 5,
  parameter int NCHK      = 2,
  parameter int NWB       = 2,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input logic              clk,
  input logic              rst,
  hazard_scoreboard_if.slave sb
);
  localparam int NIDX = 1 << REG_W;

  logic [NREGS-1:0] pending_reg;
  logic [ROW_W-1:0] row_reg [NREGS];
  logic [CNT_W-1:0] cnt_reg;

  logic [NREGS-1:0] wb_clr;
  logic [NREGS-1:0] busy_vec;
  logic [NIDX-1:0]  busy_ext;
  logic             iss_stalled;
  logic             id_stalled;
  logic             issue_fire;

  // A writeback clears only when its row tag matches the live allocation.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [NWB-1:0] hit;
      for (genvar gp = 0; gp < NWB; gp++) begin : g_port
        assign hit[gp] = sb.wb_valid[gp]
                      && (sb.wb_dst[gp*REG_W +: REG_W] == REG_W'(gi))
                      && pending_reg[gi]
                      && (row_reg[gi] == sb.wb_row[gp*ROW_W +: ROW_W]);
      end
      assign wb_clr[gi] = |hit;
    end
  endgenerate

  assign busy_vec = pending_reg & ~((WB_BYPASS != 0) ? wb_clr : '0);

  // Indices beyond NREGS read as idle through the zero padding.
  always_comb begin
    busy_ext = '0;
    busy_ext[NREGS-1:0] = busy_vec;
    busy_ext[0] = 1'b0;
  end

  always_comb begin
    iss_stalled = 1'b0;
    for (int k = 0; k < NCHK; k++) begin
      if (sb.iss_check[k] && busy_ext[sb.iss_src[k*REG_W +: REG_W]])
        iss_stalled = 1'b1;
    end
    iss_stalled = iss_stalled && sb.iss_valid;
  end

  // The in-flight Issue destination blocks Decode readers even when Issue stalls.
  always_comb begin
    id_stalled = iss_stalled;
    for (int k = 0; k < NCHK; k++) begin
      if (sb.id_check[k] && (sb.id_src[k*REG_W +: REG_W] != '0)
          && (busy_ext[sb.id_src[k*REG_W +: REG_W]]
              || (sb.iss_valid && sb.iss_dst_en
                  && (sb.iss_dst == sb.id_src[k*REG_W +: REG_W]))))
        id_stalled = 1'b1;
    end
  end

  assign issue_fire = sb.iss_valid && !iss_stalled && sb.iss_dst_en && (sb.iss_dst != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= '0;
      for (int r = 0; r < NREGS; r++) row_reg[r] <= '0;
    end else if (sb.flush) begin
      pending_reg <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (issue_fire && (sb.iss_dst == REG_W'(r))) begin
          pending_reg[r] <= 1'b1;
          row_reg[r]     <= sb.iss_row;
        end else if (wb_clr[r]) begin
          pending_reg[r] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_reg <= '0;
    else if (iss_stalled && (cnt_reg != '1))
      cnt_reg <= cnt_reg + 1'b1;
  end

  assign sb.iss_stalled  = iss_stalled;
  assign sb.id_stalled   = id_stalled;
  assign sb.pending_vec  = pending_reg;
  assign sb.stall_cycles = cnt_reg;
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the combinational ARF hazard check: owns the per-register pending-write state itself rather than receiving pending/row pairs from outside.
- Sets pending on issue, clears on tagged writeback, and generates Issue-stage and Decode-stage stalls for NCHK source operands per stage.
- Adds in-flight issue forwarding for Decode, writeback bypass, flush, and a saturating stall-cycle counter.
- Sits between Decode/Issue and the writeback buses.

Parameters:
- NREGS, 32, architectural registers; register 0 is never pending.
- REG_W, 5, register index width; NREGS <= 2**REG_W.
- ROW_W, 5, assignment-row tag width.
- NCHK, 2, source operands checked per stage.
- NWB, 2, writeback ports.
- WB_BYPASS, 1, 1 = a writeback in the current cycle cancels the stall on a matching source in that cycle.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  clear all pending state
- iss_valid  in  1  instruction present in Issue
- iss_src  in  NCHK*REG_W  Issue source indices, operand k at [k*REG_W +: REG_W]
- iss_check  in  NCHK  per-operand check enable
- iss_dst_en  in  1  Issue instruction writes a register
- iss_dst  in  REG_W  destination index
- iss_row  in  ROW_W  assignment row allocated to the destination
- iss_stalled  out  1  Issue stall
- id_src  in  NCHK*REG_W  Decode source indices
- id_check  in  NCHK  Decode check enables
- id_stalled  out  1  Decode/Fetch stall
- wb_valid  in  NWB  writeback valid per port
- wb_dst  in  NWB*REG_W  writeback destination
- wb_row  in  NWB*ROW_W  writeback row tag
- pending_vec  out  NREGS  current pending bits
- stall_cycles  out  CNT_W  count of cycles with iss_stalled=1

Behaviour:
- State: pending[NREGS] and row[NREGS][ROW_W]. Reset (async, rst=1) clears both and stall_cycles to 0. pending_vec = pending, so it reads 0 out of reset.
- wb_clr(r) = OR over ports p of (wb_valid[p] && wb_dst[p]==r && pending[r] && row[r]==wb_row[p]).
  - A writeback whose tag mismatches the stored row is stale and is ignored.
- src_busy(r) = r!=0 && pending[r] && !(WB_BYPASS && wb_clr(r)).
- iss_stalled = iss_valid && OR over k of (iss_check[k] && src_busy(iss_src[k])). Combinational, zero latency.
- issue_fire = iss_valid && !iss_stalled && iss_dst_en && iss_dst!=0.
- id_stalled = iss_stalled || OR over k of (id_check[k] && id_src[k]!=0 && (src_busy(id_src[k]) || (iss_valid && iss_dst_en && iss_dst==id_src[k]))).
  - The in-flight Issue destination always stalls a Decode reader, even if Issue itself stalls.
- Next state at posedge clk, in priority order:
  1. flush=1: all pending cleared; rows unchanged; counter still updates from the current iss_stalled.
  2. For each r: if issue_fire && iss_dst==r, then pending[r]<=1 and row[r]<=iss_row. Issue beats a same-cycle writeback to the same register.
  3. Else if wb_clr(r), pending[r]<=0.
- Pending state uses pre-edge values, so an instruction reading and writing the same register (src==dst) stalls only on the prior writer.
- Multiple wb ports hitting the same register in one cycle: clear once; no error.
- stall_cycles increments when iss_stalled=1 and saturates at all-ones. It is not cleared by flush.
- Writes to register 0 never set pending; checks of register 0 never stall.
- Indices >= NREGS: treated as not pending; issue to them is ignored.
- rst asserted mid-operation wipes state immediately, regardless of clk.

Test Plan:
1. Reset → pending_vec=0, stall_cycles=0, both stalls 0 with all checks enabled.
2. Issue dst=5 row=3, then next cycle Issue src0=5 check → iss_stalled=1, id_stalled=1. wb dst=5 row=3 with WB_BYPASS=1 → stall drops the same cycle, and pending_vec[5]=0 after the edge.
3. Pending r7 row=2; wb dst=7 row=4 → r7 stays pending, stall persists; wb row=2 → cleared.
4. Same cycle: issue_fire dst=9 row=1 and wb dst=9 with the old matching row → pending[9]=1, row[9]=1 after the edge.
5. Issue valid dst=4 (Issue not stalled), Decode id_src1=4 check → id_stalled=1, iss_stalled=0. Repeat with dst=0 → no stall.
6. Hold a stall for 3 cycles, then assert flush → stall_cycles=3, pending_vec=0 next cycle. Force the counter near max → it saturates at 2**CNT_W-1.
